// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: Q-format widths, rounding shift and saturation.
// Helpers work on a 64-bit signed carrier so every stage can reuse them.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int TW_W   = 16;

    typedef logic signed [63:0] wide_t;

    // Rounding bias for a right shift by sh: half of the discarded LSB weight.
    function automatic wide_t round_half(input int unsigned sh);
        if (sh == 0) begin
            return wide_t'(0);
        end
        return wide_t'(1) <<< (sh - 1);
    endfunction

    function automatic wide_t rshift_round(input wide_t v, input int unsigned sh, input bit rh);
        wide_t biased;
        biased = v + (rh ? round_half(sh) : wide_t'(0));
        return biased >>> sh;
    endfunction

    function automatic wide_t sat(input wide_t v, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cmult_pipe.sv
// One-register complex multiply x*tw with optional rounding; keeps WIDTH+1 bits.
// Products are held at full width so tw = -1.0 needs no special case.
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int TW_WIDTH = TW_W,
    parameter int RH       = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic signed [WIDTH-1:0]    x_re,
    input  logic signed [WIDTH-1:0]    x_im,
    input  logic signed [TW_WIDTH-1:0] tw_re,
    input  logic signed [TW_WIDTH-1:0] tw_im,
    input  logic                       bypass,
    output logic signed [WIDTH:0]      p_re,
    output logic signed [WIDTH:0]      p_im
);

    localparam int PW = WIDTH + TW_WIDTH + 1;

    logic signed [PW-1:0] full_re;
    logic signed [PW-1:0] full_im;
    wide_t                sh_re;
    wide_t                sh_im;

    always_comb begin
        full_re = PW'(x_re) * PW'(tw_re) - PW'(x_im) * PW'(tw_im);
        full_im = PW'(x_re) * PW'(tw_im) + PW'(x_im) * PW'(tw_re);
        sh_re   = rshift_round(wide_t'(full_re), TW_WIDTH - 1, RH != 0);
        sh_im   = rshift_round(wide_t'(full_im), TW_WIDTH - 1, RH != 0);
    end

    // Bypass passes x through exactly, i.e. W = 1 with no rounding error.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en) begin
            p_re <= bypass ? (WIDTH+1)'(x_re) : (WIDTH+1)'(sh_re);
            p_im <= bypass ? (WIDTH+1)'(x_im) : (WIDTH+1)'(sh_im);
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: capture, complex multiply, add/sub+scale+saturate.
// A single global advance signal stalls every stage together under backpressure.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int TW_WIDTH = TW_W,
    parameter int RH       = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    x0_re,
    input  logic signed [WIDTH-1:0]    x0_im,
    input  logic signed [WIDTH-1:0]    x1_re,
    input  logic signed [WIDTH-1:0]    x1_im,
    input  logic signed [TW_WIDTH-1:0] tw_re,
    input  logic signed [TW_WIDTH-1:0] tw_im,
    input  logic                       tw_bypass,
    input  logic                       scale,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    y0_re,
    output logic signed [WIDTH-1:0]    y0_im,
    output logic signed [WIDTH-1:0]    y1_re,
    output logic signed [WIDTH-1:0]    y1_im,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    logic adv;
    logic v1, v2;
    logic signed [WIDTH-1:0]    x0r1, x0i1, x1r1, x1i1, x0r2, x0i2;
    logic signed [TW_WIDTH-1:0] twr1, twi1;
    logic                       byp1, scale1, scale2;
    logic signed [WIDTH:0]      p_re, p_im;

    logic signed [WIDTH+1:0] pre [4];
    wide_t                   scl [4];
    wide_t                   clp [4];
    logic [3:0]              clip;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    cmult_pipe #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .RH(RH)) u_cmult (
        .clock  (clock),
        .reset  (reset),
        .en     (adv),
        .x_re   (x1r1),
        .x_im   (x1i1),
        .tw_re  (twr1),
        .tw_im  (twi1),
        .bypass (byp1),
        .p_re   (p_re),
        .p_im   (p_im)
    );

    // Order of pre[] is y0_re, y0_im, y1_re, y1_im.
    always_comb begin
        pre[0] = (WIDTH+2)'(x0r2) + (WIDTH+2)'(p_re);
        pre[1] = (WIDTH+2)'(x0i2) + (WIDTH+2)'(p_im);
        pre[2] = (WIDTH+2)'(x0r2) - (WIDTH+2)'(p_re);
        pre[3] = (WIDTH+2)'(x0i2) - (WIDTH+2)'(p_im);
        clip   = '0;
        for (int i = 0; i < 4; i++) begin
            scl[i]  = scale2 ? rshift_round(wide_t'(pre[i]), 1, RH != 0) : wide_t'(pre[i]);
            clp[i]  = sat(scl[i], WIDTH);
            clip[i] = (clp[i] != scl[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            x0r1      <= '0;
            x0i1      <= '0;
            x1r1      <= '0;
            x1i1      <= '0;
            twr1      <= '0;
            twi1      <= '0;
            byp1      <= 1'b0;
            scale1    <= 1'b0;
            x0r2      <= '0;
            x0i2      <= '0;
            scale2    <= 1'b0;
            y0_re     <= '0;
            y0_im     <= '0;
            y1_re     <= '0;
            y1_im     <= '0;
            ovf       <= 1'b0;
        end else begin
            if (adv) begin
                v1        <= in_valid;
                x0r1      <= x0_re;
                x0i1      <= x0_im;
                x1r1      <= x1_re;
                x1i1      <= x1_im;
                twr1      <= tw_re;
                twi1      <= tw_im;
                byp1      <= tw_bypass;
                scale1    <= scale;
                v2        <= v1;
                x0r2      <= x0r1;
                x0i2      <= x0i1;
                scale2    <= scale1;
                out_valid <= v2;
                y0_re     <= WIDTH'(clp[0]);
                y0_im     <= WIDTH'(clp[1]);
                y1_re     <= WIDTH'(clp[2]);
                y1_im     <= WIDTH'(clp[3]);
            end
            // A saturating beat entering the output register beats a same-cycle clear.
            if (adv && v2 && (clip != 4'b0000)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: RH=0 and RH=1 instances driven in lockstep,
// expected outputs computed from an integer model when each beat is accepted.
module tb_butterfly_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, in_valid, tw_bypass, scale, out_ready, ovf_clr;
    logic signed [15:0] x0_re, x0_im, x1_re, x1_im, tw_re, tw_im;

    logic a_in_ready, a_out_valid, a_ovf;
    logic b_in_ready, b_out_valid, b_ovf;
    logic signed [15:0] a_y0_re, a_y0_im, a_y1_re, a_y1_im;
    logic signed [15:0] b_y0_re, b_y0_im, b_y1_re, b_y1_im;

    butterfly_pipe #(.WIDTH(16), .TW_WIDTH(16), .RH(0)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .tw_re(tw_re), .tw_im(tw_im), .tw_bypass(tw_bypass), .scale(scale),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .y0_re(a_y0_re), .y0_im(a_y0_im), .y1_re(a_y1_re), .y1_im(a_y1_im),
        .ovf(a_ovf), .ovf_clr(ovf_clr)
    );

    butterfly_pipe #(.WIDTH(16), .TW_WIDTH(16), .RH(1)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .tw_re(tw_re), .tw_im(tw_im), .tw_bypass(tw_bypass), .scale(scale),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .y0_re(b_y0_re), .y0_im(b_y0_im), .y1_re(b_y1_re), .y1_im(b_y1_im),
        .ovf(b_ovf), .ovf_clr(ovf_clr)
    );

    logic signed [15:0] ya [4];
    logic signed [15:0] yb [4];
    assign ya[0] = a_y0_re;
    assign ya[1] = a_y0_im;
    assign ya[2] = a_y1_re;
    assign ya[3] = a_y1_im;
    assign yb[0] = b_y0_re;
    assign yb[1] = b_y0_im;
    assign yb[2] = b_y1_re;
    assign yb[3] = b_y1_im;

    typedef struct {
        logic signed [15:0] a [4];
        logic signed [15:0] b [4];
    } exp_t;

    exp_t sb [$];
    int   n_assert = 0;
    int   n_fail   = 0;
    string comp_name [4] = '{"y0_re", "y0_im", "y1_re", "y1_im"};

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Q1.15 product, optional round-half-up, floor shift by 15.
    function automatic longint prod(input int rh, input int a, input int b,
                                    input int c, input int d, input bit minus);
        longint t;
        t = minus ? longint'(a) * longint'(b) - longint'(c) * longint'(d)
                  : longint'(a) * longint'(b) + longint'(c) * longint'(d);
        if (rh != 0) t = t + 16384;
        return t >>> 15;
    endfunction

    function automatic logic signed [15:0] comp(input int rh, input longint x0, input longint p,
                                                input bit neg, input bit scl);
        longint s;
        s = neg ? x0 - p : x0 + p;
        if (scl) s = (s + longint'(rh)) >>> 1;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic apply_stimulus(input int a0r, input int a0i, input int a1r, input int a1i,
                                  input int twr, input int twi, input bit byp, input bit scl,
                                  input bit hold);
        exp_t   e;
        longint pr, pi;
        bit     acc;
        int     guard;
        x0_re = 16'(a0r);
        x0_im = 16'(a0i);
        x1_re = 16'(a1r);
        x1_im = 16'(a1i);
        tw_re = 16'(twr);
        tw_im = 16'(twi);
        tw_bypass = byp;
        scale     = scl;
        in_valid  = 1'b1;
        for (int rh = 0; rh < 2; rh++) begin
            pr = byp ? longint'(a1r) : prod(rh, a1r, twr, a1i, twi, 1'b1);
            pi = byp ? longint'(a1i) : prod(rh, a1r, twi, a1i, twr, 1'b0);
            if (rh == 0) begin
                e.a[0] = comp(rh, a0r, pr, 1'b0, scl);
                e.a[1] = comp(rh, a0i, pi, 1'b0, scl);
                e.a[2] = comp(rh, a0r, pr, 1'b1, scl);
                e.a[3] = comp(rh, a0i, pi, 1'b1, scl);
            end else begin
                e.b[0] = comp(rh, a0r, pr, 1'b0, scl);
                e.b[1] = comp(rh, a0i, pi, 1'b0, scl);
                e.b[2] = comp(rh, a0r, pr, 1'b1, scl);
                e.b[3] = comp(rh, a0i, pi, 1'b1, scl);
            end
        end
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 100) begin
            @(negedge clock);
            acc = a_in_ready;
            @(posedge clock);
            #1;
            guard++;
        end
        if (!acc) check_output("accept", 32'(acc), 32'(1));
        else sb.push_back(e);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_output(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!a_out_valid && n < 50);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks outputs hold while stalled.
    logic signed [15:0] held [4];
    bit stalled = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (a_out_valid) check_output("in_ready_stall", 32'(a_in_ready), 32'(out_ready));
            if (stalled && a_out_valid) begin
                for (int i = 0; i < 4; i++) check_output({"hold_", comp_name[i]}, 32'(ya[i]), 32'(held[i]));
            end
            if (a_out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_beat", 32'(a_out_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check_output("b_out_valid", 32'(b_out_valid), 32'(1));
                    for (int i = 0; i < 4; i++) begin
                        check_output({"rh0_", comp_name[i]}, 32'(ya[i]), 32'(e.a[i]));
                        check_output({"rh1_", comp_name[i]}, 32'(yb[i]), 32'(e.b[i]));
                    end
                end
            end
            stalled = a_out_valid && !out_ready;
            held    = ya;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int guard;
        reset = 1'b1; in_valid = 1'b0; tw_bypass = 1'b0; scale = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        x0_re = '0; x0_im = '0; x1_re = '0; x1_im = '0; tw_re = '0; tw_im = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("rst_out_valid", 32'(a_out_valid), 32'(0));
        check_output("rst_ovf", 32'(a_ovf), 32'(0));
        check_output("rst_y0_re", 32'(a_y0_re), 32'(0));
        check_output("rst_y1_im", 32'(b_y1_im), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        // Bypass add/sub, twiddle values must be ignored; latency 3.
        apply_stimulus(100, -50, 30, 20, 12345, -777, 1'b1, 1'b0, 1'b0);
        wait_output(lat);
        check_output("latency_t1", 32'(lat), 32'(3));
        check_output("ovf_t1", 32'(a_ovf), 32'(0));
        @(posedge clock); #1;

        // Multiply by -j and a general twiddle.
        apply_stimulus(0, 0, 1000, 0, 0, -32768, 1'b0, 1'b0, 1'b0);
        wait_output(lat);
        @(posedge clock); #1;
        apply_stimulus(-20000, 15000, 12000, -9000, 23170, -23170, 1'b0, 1'b1, 1'b0);
        wait_output(lat);
        @(posedge clock); #1;

        // Saturation, sticky flag, clear, then the scaled beat stays in range.
        apply_stimulus(32767, 0, 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_output(lat);
        check_output("ovf_set_a", 32'(a_ovf), 32'(1));
        check_output("ovf_set_b", 32'(b_ovf), 32'(1));
        @(posedge clock); #1;
        ovf_clr = 1'b1;
        @(posedge clock); #1;
        ovf_clr = 1'b0;
        @(negedge clock);
        check_output("ovf_clr_a", 32'(a_ovf), 32'(0));
        check_output("ovf_clr_b", 32'(b_ovf), 32'(0));
        @(posedge clock); #1;
        apply_stimulus(32767, 0, 1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        wait_output(lat);
        check_output("ovf_scaled_a", 32'(a_ovf), 32'(0));
        @(posedge clock); #1;

        // Rounding versus truncation on a scaled beat.
        apply_stimulus(3, -3, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        wait_output(lat);
        @(posedge clock); #1;

        // 16-beat ramp with a 5-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    apply_stimulus(i * 100, -i * 50, i * 7, 3 * i - 20, 23170, -23170,
                                   1'b0, bit'(i % 2), 1'b1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clock);
            guard++;
        end
        check_output("ramp_drain", 32'(sb.size()), 32'(0));
        @(posedge clock); #1;

        // Reset with three beats in flight, then a fresh beat.
        out_ready = 1'b0;
        apply_stimulus(111, 222, 5, 6, 0, 0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(333, 444, 7, 8, 0, 0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(555, 666, 9, 10, 0, 0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        @(negedge clock);
        check_output("flush_valid_a", 32'(a_out_valid), 32'(0));
        check_output("flush_valid_b", 32'(b_out_valid), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        apply_stimulus(-7, 9, 40, -40, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_output(lat);
        check_output("latency_t6", 32'(lat), 32'(3));
        repeat (3) @(posedge clock);
        check_output("final_drain", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
